// File: rtl/jt08_adpcm_seq.sv
// Six-channel ADPCM slot sequencer: rotates slots on cen, fetches one ROM nibble per
// enabled slot, and reports sample-ready, end-of-sample and fetch-underrun to the accumulator.
module jt08_adpcm_seq #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          wr,
  input  logic [3:0]    addr,
  input  logic [15:0]   din,
  output logic          rom_req,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ack,
  output logic [5:0]    cur_ch,
  output logic [5:0]    en_ch,
  output logic          match,
  output logic          en_sum,
  output logic [5:0]    flags,
  output logic          ovr
);

  localparam int unsigned NCH = 6;
  localparam int unsigned CW  = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     r_state;
  logic           r_cen_d;
  logic [NCH-1:0] r_cur_ch, r_en_ch, r_flags, r_kon, r_koff, r_end_hit;
  logic           r_match, r_en_sum, r_rom_req, r_ovr;
  logic [AW-1:0]  r_rom_addr;
  logic [AW-1:0]  r_cnt   [NCH];
  logic [AW-1:0]  r_start [NCH];
  logic [AW-1:0]  r_end   [NCH];

  logic [1:0]     w_state_nxt;
  logic [CW-1:0]  w_ch;
  logic [NCH-1:0] w_cur_nxt, w_en_nxt, w_kon_nxt, w_koff_nxt, w_end_hit_nxt;
  logic [NCH-1:0] w_flags_set, w_flags_clr, w_flags_nxt;
  logic           w_match_nxt, w_en_sum_nxt, w_req_nxt;
  logic           w_ovr_set, w_ovr_clr, w_ovr_nxt;
  logic [AW-1:0]  w_addr_nxt;
  logic [AW-1:0]  w_cnt_nxt   [NCH];
  logic [AW-1:0]  w_start_nxt [NCH];
  logic [AW-1:0]  w_end_nxt   [NCH];

  // Slot FSM, key-on/off application and register decode
  always_comb begin
    w_ch          = '0;
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur_ch;
    w_en_nxt      = r_en_ch;
    w_match_nxt   = r_match;
    w_en_sum_nxt  = r_en_sum;
    w_req_nxt     = r_rom_req;
    w_addr_nxt    = r_rom_addr;
    w_kon_nxt     = r_kon;
    w_koff_nxt    = r_koff;
    w_end_hit_nxt = r_end_hit;
    w_flags_set   = '0;
    w_flags_clr   = '0;
    w_ovr_set     = 1'b0;
    w_ovr_clr     = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_start_nxt   = r_start;
    w_end_nxt     = r_end;

    for (int i = 0; i < NCH; i++) begin
      if (r_cur_ch[i]) w_ch = CW'(i);
    end

    if (cen) begin
      w_cur_nxt = {r_cur_ch[NCH-2:0], r_cur_ch[NCH-1]};
      // key-off beats key-on; key-on beats the end-of-sample clear
      w_en_nxt  = ((r_en_ch & ~r_end_hit) | r_kon) & ~r_koff;
      for (int i = 0; i < NCH; i++) begin
        if (r_kon[i] && !r_koff[i]) w_cnt_nxt[i] = r_start[i];
      end
      w_en_sum_nxt  = |(w_cur_nxt & w_en_nxt);
      w_flags_set   = r_end_hit;
      w_end_hit_nxt = '0;
      w_ovr_set     = (r_state == ST_REQ);
      w_req_nxt     = 1'b0;
      w_match_nxt   = 1'b0;
      w_state_nxt   = ST_IDLE;
      w_kon_nxt     = '0;
      w_koff_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_cen_d) begin
            if (|(r_cur_ch & r_en_ch)) begin
              w_state_nxt = ST_REQ;
              w_req_nxt   = 1'b1;
              w_addr_nxt  = r_cnt[w_ch];
            end else begin
              w_state_nxt = ST_DONE;
              w_match_nxt = 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (rom_ack) begin
            w_state_nxt     = ST_DONE;
            w_req_nxt       = 1'b0;
            w_match_nxt     = 1'b1;
            w_cnt_nxt[w_ch] = r_cnt[w_ch] + AW'(1);
            if (r_rom_addr == r_end[w_ch]) w_end_hit_nxt[w_ch] = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (wr) begin
      case (addr)
        4'd0: w_kon_nxt  = w_kon_nxt | din[NCH-1:0];
        4'd1: w_koff_nxt = w_koff_nxt | din[NCH-1:0];
        4'd2: begin
          w_flags_clr = din[NCH-1:0];
          w_ovr_clr   = din[15];
        end
        default: ;
      endcase
      if (addr >= 4'd4 && addr <= 4'd9) w_start_nxt[CW'(addr - 4'd4)] = AW'(din);
      if (addr >= 4'd10) w_end_nxt[CW'(addr - 4'd10)] = AW'(din);
    end

    w_flags_nxt = (r_flags & ~w_flags_clr) | w_flags_set;
    w_ovr_nxt   = (r_ovr & ~w_ovr_clr) | w_ovr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cen_d    <= 1'b0;
      r_cur_ch   <= NCH'(1);
      r_en_ch    <= '0;
      r_flags    <= '0;
      r_kon      <= '0;
      r_koff     <= '0;
      r_end_hit  <= '0;
      r_match    <= 1'b0;
      r_en_sum   <= 1'b0;
      r_rom_req  <= 1'b0;
      r_ovr      <= 1'b0;
      r_rom_addr <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]   <= '0;
        r_start[i] <= '0;
        r_end[i]   <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_cen_d    <= cen;
      r_cur_ch   <= w_cur_nxt;
      r_en_ch    <= w_en_nxt;
      r_flags    <= w_flags_nxt;
      r_kon      <= w_kon_nxt;
      r_koff     <= w_koff_nxt;
      r_end_hit  <= w_end_hit_nxt;
      r_match    <= w_match_nxt;
      r_en_sum   <= w_en_sum_nxt;
      r_rom_req  <= w_req_nxt;
      r_ovr      <= w_ovr_nxt;
      r_rom_addr <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_start    <= w_start_nxt;
      r_end      <= w_end_nxt;
    end
  end

  assign rom_req  = r_rom_req;
  assign rom_addr = r_rom_addr;
  assign cur_ch   = r_cur_ch;
  assign en_ch    = r_en_ch;
  assign match    = r_match;
  assign en_sum   = r_en_sum;
  assign flags    = r_flags;
  assign ovr      = r_ovr;

endmodule

// File: tb/tb_jt08_adpcm_seq.sv
// Bench for jt08_adpcm_seq: directed slot sequences plus random register/ack traffic
// compared every clock against a slot-level reference model.
module tb_jt08_adpcm_seq;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst, cen, wr, rom_ack;
  logic [3:0]    addr;
  logic [15:0]   din;
  logic          rom_req, match, en_sum, ovr;
  logic [AW-1:0] rom_addr;
  logic [5:0]    cur_ch, en_ch, flags;

  jt08_adpcm_seq #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .cur_ch(cur_ch), .en_ch(en_ch), .match(match), .en_sum(en_sum),
    .flags(flags), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: slot number, phase 0=waiting 1=fetching 2=ready
  int          m_slot, m_phase;
  bit          m_cen_d, m_ovr, m_ensum;
  logic [5:0]  m_en, m_kon, m_koff, m_endhit, m_flags;
  int unsigned m_cnt [6];
  int unsigned m_start [6];
  int unsigned m_end [6];
  int unsigned m_raddr;

  int unsigned q_addr [$];

  typedef struct {
    int         n_cen;
    logic [5:0] exp_cur;
    bit         exp_match;
    bit         exp_ensum;
  } vec_t;
  vec_t tbl [7];

  localparam logic [37:0] RST_VEC = {6'h01, 6'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 6'h00, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_phase = 0; m_cen_d = 0; m_ovr = 0; m_ensum = 0;
    m_en = '0; m_kon = '0; m_koff = '0; m_endhit = '0; m_flags = '0; m_raddr = 0;
    for (int i = 0; i < 6; i++) begin
      m_cnt[i] = 0; m_start[i] = 0; m_end[i] = 0;
    end
  endtask

  task automatic model_step();
    int a;
    logic [5:0] wkon, wkoff, fclr, fset;
    bit oclr, oset;
    if (rst) begin
      model_reset();
      return;
    end
    a = int'(addr);
    wkon = '0; wkoff = '0; fclr = '0; fset = '0; oclr = 0; oset = 0;
    if (wr && a == 0) wkon = din[5:0];
    if (wr && a == 1) wkoff = din[5:0];
    if (wr && a == 2) begin fclr = din[5:0]; oclr = din[15]; end
    if (cen) begin
      for (int ch = 0; ch < 6; ch++) begin
        if (m_koff[ch]) m_en[ch] = 1'b0;
        else if (m_kon[ch]) begin m_en[ch] = 1'b1; m_cnt[ch] = m_start[ch]; end
        else if (m_endhit[ch]) m_en[ch] = 1'b0;
      end
      fset = m_endhit;
      oset = (m_phase == 1);
      m_slot = (m_slot + 1) % 6;
      m_ensum = m_en[m_slot];
      m_phase = 0; m_endhit = '0; m_kon = wkon; m_koff = wkoff;
    end else begin
      if (m_phase == 0 && m_cen_d) begin
        if (m_en[m_slot]) begin m_phase = 1; m_raddr = m_cnt[m_slot]; end
        else m_phase = 2;
      end else if (m_phase == 1 && rom_ack) begin
        m_phase = 2;
        if (m_raddr == m_end[m_slot]) m_endhit[m_slot] = 1'b1;
        m_cnt[m_slot] = (m_cnt[m_slot] + 1) % 65536;
      end
      m_kon = m_kon | wkon;
      m_koff = m_koff | wkoff;
    end
    m_cen_d = cen;
    m_flags = (m_flags & ~fclr) | fset;
    m_ovr = (m_ovr && !oclr) || oset;
    if (wr && a >= 4 && a <= 9) m_start[a-4] = int'(din);
    if (wr && a >= 10) m_end[a-10] = int'(din);
  endtask

  function automatic logic [37:0] model_vec();
    return {6'(1 << m_slot), m_en, (m_phase == 2), m_ensum, (m_phase == 1),
            16'(m_raddr), m_flags, m_ovr};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle {cur,en,match,en_sum,req,addr,flags,ovr}",
          64'({cur_ch, en_ch, match, en_sum, rom_req, rom_addr, flags, ovr}), 64'(model_vec()));
    cen = 0; wr = 0; rom_ack = 0; rst = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick();
    rst = 1; tick();
    check("reset outputs", 64'({cur_ch, en_ch, match, en_sum, rom_req, rom_addr, flags, ovr}),
          64'(RST_VEC));
  endtask

  task automatic write(input int a, input int d);
    wr = 1; addr = 4'(a); din = 16'(d);
    tick();
  endtask

  // One slot: cen then 6 clocks; ack ack_dly clocks after rom_req rises (<0 withholds)
  task automatic run_slot(input int ack_dly);
    bit seen;
    seen = 0;
    cen = 1; tick();
    for (int k = 1; k <= 6; k++) begin
      if (m_phase == 1 && !seen) begin
        seen = 1;
        q_addr.push_back(int'(rom_addr));
      end
      if (ack_dly >= 0 && m_phase == 1 && k == 1 + ack_dly) rom_ack = 1;
      tick();
    end
  endtask

  initial begin
    rst = 1; cen = 0; wr = 0; rom_ack = 0; addr = '0; din = '0;
    model_reset();

    tbl[0] = '{1, 6'h02, 1, 0};
    tbl[1] = '{1, 6'h04, 1, 0};
    tbl[2] = '{1, 6'h08, 1, 0};
    tbl[3] = '{1, 6'h10, 1, 0};
    tbl[4] = '{1, 6'h20, 1, 0};
    tbl[5] = '{1, 6'h01, 1, 0};
    tbl[6] = '{1, 6'h02, 1, 0};

    // Idle rotation after reset
    do_reset();
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < tbl[i].n_cen; j++) run_slot(-1);
      check("rotate cur_ch", 64'(cur_ch), 64'(tbl[i].exp_cur));
      check("rotate match", 64'(match), 64'(tbl[i].exp_match));
      check("rotate en_sum", 64'(en_sum), 64'(tbl[i].exp_ensum));
    end

    // ch2 plays 0x100..0x102 then ends
    do_reset();
    write(6, 'h100); write(12, 'h102); write(0, 'h04);
    q_addr.delete();
    for (int s = 0; s < 40 && q_addr.size() < 3; s++) run_slot(2);
    check("ch2 fetch count", 64'(q_addr.size()), 64'(3));
    if (q_addr.size() >= 3) begin
      check("ch2 addr0", 64'(q_addr[0]), 64'h100);
      check("ch2 addr1", 64'(q_addr[1]), 64'h101);
      check("ch2 addr2", 64'(q_addr[2]), 64'h102);
    end
    run_slot(2);
    check("ch2 end flags", 64'(flags), 64'h04);
    check("ch2 end en_ch", 64'(en_ch), 64'h00);

    // key-on and key-off together: key-off wins
    do_reset();
    write(0, 1); write(1, 1);
    q_addr.delete();
    repeat (7) run_slot(1);
    check("kon+koff en_ch", 64'(en_ch), 64'h00);
    check("kon+koff fetches", 64'(q_addr.size()), 64'(0));

    // ch1 underrun then reissue
    do_reset();
    write(5, 'h20); write(11, 'h30); write(0, 'h02);
    q_addr.delete();
    for (int s = 0; s < 20 && q_addr.size() < 1; s++) run_slot(-1);
    check("underrun req pending", 64'(rom_req), 64'(1));
    cen = 1; tick();
    check("underrun ovr", 64'(ovr), 64'(1));
    check("underrun req dropped", 64'(rom_req), 64'(0));
    check("underrun match", 64'(match), 64'(0));
    repeat (6) tick();
    q_addr.delete();
    for (int s = 0; s < 20 && q_addr.size() < 1; s++) run_slot(1);
    check("reissue addr", 64'(q_addr.size() > 0 ? q_addr[0] : 32'hdead), 64'h20);

    // ch3 wraps past 0xFFFF
    do_reset();
    write(7, 'hFFFF); write(13, 'h0001); write(0, 'h08);
    q_addr.delete();
    for (int s = 0; s < 40 && q_addr.size() < 3; s++) run_slot(1);
    check("wrap fetch count", 64'(q_addr.size()), 64'(3));
    if (q_addr.size() >= 3) begin
      check("wrap addr0", 64'(q_addr[0]), 64'hFFFF);
      check("wrap addr1", 64'(q_addr[1]), 64'h0000);
      check("wrap addr2", 64'(q_addr[2]), 64'h0001);
    end
    run_slot(1);
    check("wrap flags", 64'(flags), 64'h08);

    // reset mid-fetch with a late ack
    do_reset();
    write(4, 'h55); write(0, 'h01);
    q_addr.delete();
    for (int s = 0; s < 20 && q_addr.size() < 1; s++) run_slot(-1);
    check("pre-reset req", 64'(rom_req), 64'(1));
    rst = 1; tick();
    rom_ack = 1; tick();
    check("reset mid-fetch outputs",
          64'({cur_ch, en_ch, match, en_sum, rom_req, rom_addr, flags, ovr}), 64'(RST_VEC));
    write(0, 'h01);
    q_addr.delete();
    for (int s = 0; s < 20 && q_addr.size() < 1; s++) run_slot(1);
    check("post-reset start addr", 64'(q_addr.size() > 0 ? q_addr[0] : 32'hdead), 64'h0);

    // Random traffic against the model
    do_reset();
    for (int s = 0; s < 250; s++) begin
      for (int k = 0; k < 7; k++) begin
        cen = (k == 0);
        if ($urandom % 4 == 0) begin
          wr = 1;
          addr = 4'($urandom % 16);
          case (addr)
            4'd0:    din = 16'($urandom % 64);
            4'd1:    din = ($urandom % 4 == 0) ? 16'($urandom % 64) : 16'h0;
            4'd2:    din = 16'($urandom);
            default: din = 16'($urandom % 16);
          endcase
        end
        rom_ack = ($urandom % 3 == 0);
        rst = ($urandom % 400 == 0);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jt08_adpcm_seq.md
JT08_ADPCM_SEQ -- requirements
Module: jt08_adpcm_seq

Interface
REQ-001 SHALL have parameter AW, default 16, ROM nibble-address width.
REQ-002 SHALL have port clk  input  1  system clock; single clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cen  input  1  slot strobe, 111 kHz, one clk wide; at least 4 clk between strobes.
REQ-005 SHALL have port wr  input  1  register write strobe.
REQ-006 SHALL have port addr  input  4  register select.
REQ-007 SHALL have port din  input  16  register write data.
REQ-008 SHALL have port rom_req  output  1  nibble fetch request.
REQ-009 SHALL have port rom_addr  output  AW  nibble address, valid while rom_req is high.
REQ-010 SHALL have port rom_ack  input  1  fetch done; single clk pulse.
REQ-011 SHALL have port cur_ch  output  6  one-hot current slot, to the accumulator.
REQ-012 SHALL have port en_ch  output  6  channel-active mask, to the accumulator.
REQ-013 SHALL have port match  output  1  slot sample ready, to the accumulator.
REQ-014 SHALL have port en_sum  output  1  include slot sample in the sum.
REQ-015 SHALL have port flags  output  6  sticky end-of-sample flags.
REQ-016 SHALL have port ovr  output  1  sticky fetch-underrun flag.

Function
REQ-017 SHALL decode register writes (wr=1) as: addr 0 key-on mask din[5:0]; addr 1 key-off mask din[5:0]; addr 2 clear flags din[5:0], with din[15] clearing ovr; addr 4..9 start address of channel 0..5 (din[AW-1:0]); addr 10..15 end address of channel 0..5; addr 3 ignored.
REQ-018 SHALL OR key-on and key-off masks into pending registers and apply them only on the next cen, then clear them.
REQ-019 SHALL, on applied key-on, load the channel address counter from its start address and set the en_ch bit.
REQ-020 SHALL, on applied key-off, clear the en_ch bit.
REQ-021 SHALL give key-off priority when key-on and key-off are pending for the same channel.
REQ-022 SHALL take effect immediately for start/end writes; a running counter is not reloaded.
REQ-023 SHALL rotate cur_ch left by one on each cen, wrapping bit5 to bit0.
REQ-024 SHALL compute en_sum as (cur_ch & en_ch) != 0, using post-cen values.
REQ-025 SHALL run the slot FSM IDLE -> REQ -> DONE.
REQ-026 SHALL, in the clk after cen, go to REQ if the slot channel is enabled (rom_req=1, rom_addr = that channel's counter), else go to DONE.
REQ-027 SHALL, in REQ on rom_ack, drop rom_req, go to DONE, and increment the counter modulo 2^AW.
REQ-028 SHALL hold match=1 in DONE and match=0 in IDLE and REQ.
REQ-029 SHALL treat a disabled slot as DONE (match=1, en_sum=0), so the accumulator restarts its sum at cur_ch[0].
REQ-030 SHALL, on cen while in REQ, set ovr, drop rom_req, set match=0 for that cycle, and leave the counter unchanged.
REQ-031 SHALL return the FSM to IDLE on every cen.
REQ-032 SHALL, when an acknowledged fetch used address == end address, set flags[ch] and clear en_ch[ch] on the following cen; wrap-around past 2^AW-1 is legal.
REQ-033 SHALL let an applied key-on restart a channel that ended on the same cen; the end-of-sample clear is superseded and the flag is still set.
REQ-034 SHALL give a set priority over a clear on the same clk for flags and ovr.
REQ-035 SHALL ignore rom_ack outside REQ.

Reset
REQ-036 SHALL, while rst=1, set cur_ch=6'b000001, en_ch=0, match=0, en_sum=0, rom_req=0, rom_addr=0, flags=0, ovr=0, FSM=IDLE, and clear pending masks, counters, start and end registers.
REQ-037 SHALL let rst asserted mid-fetch drop rom_req in the next clk and discard any later rom_ack.
REQ-038 SHALL ignore cen and wr while rst=1.

Verification
REQ-039 SHALL be checked by: after reset, 7 cen pulses -> cur_ch sequence 02,04,08,10,20,01,02; match=1 after each; en_sum=0.
REQ-040 SHALL be checked by: start2=0x100, end2=0x102, key-on 0x04, ack each fetch 2 clk after rom_req -> rom_addr 0x100, 0x101, 0x102 on successive ch2 slots; flags=0x04; en_ch=0 after the next cen.
REQ-041 SHALL be checked by: key-on 0x01 and key-off 0x01 in the same cen window -> en_ch[0] stays 0; no rom_req.
REQ-042 SHALL be checked by: ch1 active, rom_ack withheld -> at cen ovr=1, rom_req=0, counter unchanged; next ch1 slot reissues the same rom_addr.
REQ-043 SHALL be checked by: start3=0xFFFF, end3=0x0001, AW=16 -> addresses FFFF, 0000, 0001, then flags[3]=1.
REQ-044 SHALL be checked by: rst pulse while rom_req=1, rom_ack arriving 1 clk later -> all outputs at reset values; counters unchanged by the ack.
